reg_cfg_master: RTL and testbench

- Initiator side of the switch register-access interface (sel_en / wr_rd_s / addr / wr_data / rd_data / ack).
- Accepts single read/write commands from a host-side valid/ready channel and runs one bus access per command.
- Waits for ack, or for a timeout, then returns a response on a valid/ready channel.
- Sits between the testbench/host CPU model and the switch register block.

---
 rtl/reg_if_pkg.sv | 16 +
 rtl/reg_cfg_timer.sv | 42 ++++
 rtl/reg_cfg_master.sv | 135 +++++++++++++
 tb/tb_reg_cfg_master.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_if_pkg.sv
// rtl/reg_if_pkg.sv - shared encodings and defaults for the register-access interface
package reg_if_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic BUS_WR = 1'b1;
  localparam logic BUS_RD = 1'b0;

  localparam int TIMEOUT_DEFAULT    = 16;
  localparam int NUM_OF_REG_DEFAULT = 4;

endpackage

// File: rtl/reg_cfg_timer.sv
// rtl/reg_cfg_timer.sv - loadable up-counter with clear and terminal-count flag at TIMEOUT-1
module reg_cfg_timer #(
  parameter int TIMEOUT = 16,
  parameter int CW      = $clog2(TIMEOUT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          en_i,
  output logic          tc_o
);

  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc_o = (count_q == TC_VAL);

  // Saturates at terminal count so a stalled owner never sees the flag wrap away.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && !tc_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/reg_cfg_master.sv
// rtl/reg_cfg_master.sv - single-command register bus initiator with ack timeout
module reg_cfg_master
  import reg_if_pkg::*;
#(
  parameter int NUM_OF_REG = NUM_OF_REG_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       sel_en,
  output logic       wr_rd_s,
  output logic [7:0] addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_data,
  input  logic       ack,
  output logic       busy
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [8:0]    NUM_REGS = 9'(NUM_OF_REG);

  state_e     state_q;
  logic       sel_en_q;
  logic       wr_rd_s_q;
  logic [7:0] addr_q;
  logic [7:0] wr_data_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic       rsp_err_q;
  logic       busy_q;

  logic       addr_oor;
  logic       timer_tc;

  assign addr_oor  = ({1'b0, cmd_addr} >= NUM_REGS);
  assign cmd_ready = (state_q == IDLE);

  assign sel_en    = sel_en_q;
  assign wr_rd_s   = wr_rd_s_q;
  assign addr      = addr_q;
  assign wr_data   = wr_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

  // Held at zero outside ACCESS, so every access starts counting from 0.
  reg_cfg_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (state_q != ACCESS),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       ((state_q == ACCESS) && !ack),
    .tc_o       (timer_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_en_q    <= 1'b0;
      wr_rd_s_q   <= BUS_RD;
      addr_q      <= '0;
      wr_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            busy_q <= 1'b1;
            if (addr_oor) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q   <= ACCESS;
              sel_en_q  <= 1'b1;
              wr_rd_s_q <= cmd_wr;
              addr_q    <= cmd_addr;
              wr_data_q <= (cmd_wr == BUS_WR) ? cmd_wdata : 8'h00;
            end
          end
        end
        ACCESS: begin
          // ack in the final timeout cycle still counts as success.
          if (ack) begin
            state_q     <= RESP;
            sel_en_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= (wr_rd_s_q == BUS_RD) ? rd_data : 8'h00;
          end else if (timer_tc) begin
            state_q     <= RESP;
            sel_en_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          sel_en_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cfg_master.sv
// tb/tb_reg_cfg_master.sv - directed and randomized checks of reg_cfg_master against a transaction model
module tb_reg_cfg_master;

  localparam int TIMEOUT    = 16;
  localparam int NUM_OF_REG = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wr;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       sel_en;
  logic       wr_rd_s;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       ack;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_cfg_master #(
    .NUM_OF_REG (NUM_OF_REG),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .sel_en    (sel_en),
    .wr_rd_s   (wr_rd_s),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .ack       (ack),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command from offer to handshake. ack_at is the ACCESS cycle (1-based)
  // in which the responder acks; 0 means never.
  task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        input int ack_at, input logic [7:0] rdv, input int rsp_wait,
                        input logic hold_next, input logic nwr, input logic [7:0] na,
                        input logic [7:0] nwd);
    int         cyc;
    int         edges;
    logic       oor;
    logic       acked;
    int         exp_sel;
    logic       exp_err;
    logic [7:0] exp_rd;

    oor     = (int'(a) >= NUM_OF_REG);
    acked   = (ack_at >= 1) && (ack_at <= TIMEOUT);
    exp_sel = oor ? 0 : (acked ? ack_at : TIMEOUT);
    exp_err = oor || !acked;
    exp_rd  = (!exp_err && !wr) ? rdv : 8'h00;

    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = a;
    cmd_wdata = wd;
    chk("cmd_ready_before_accept", cmd_ready, 1);
    @(negedge clk);
    edges     = 1;
    cmd_valid = 1'b0;
    cmd_wr    = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = 8'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("cmd_ready_after_accept", cmd_ready, 0);

    cyc = 0;
    while (sel_en === 1'b1 && cyc < TIMEOUT + 4) begin
      cyc++;
      chk("bus_wr_rd_s", wr_rd_s, wr);
      chk("bus_addr", addr, a);
      chk("bus_wr_data", wr_data, wr ? wd : 8'h00);
      chk("rsp_valid_during_access", rsp_valid, 0);
      if (cyc == ack_at) begin
        ack     = 1'b1;
        rd_data = rdv;
      end else begin
        ack     = 1'b0;
        rd_data = 8'($urandom);
      end
      @(negedge clk);
      edges++;
    end
    ack = 1'b0;
    chk("sel_en_cycles", cyc, exp_sel);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rd);

    for (int i = 0; i < rsp_wait; i++) begin
      if (hold_next) begin
        cmd_valid = 1'b1;
        cmd_wr    = nwr;
        cmd_addr  = na;
        cmd_wdata = nwd;
      end
      ack     = 1'($urandom);
      rd_data = 8'($urandom);
      @(negedge clk);
      edges++;
      chk("rsp_valid_stall", rsp_valid, 1);
      chk("rsp_err_stall", rsp_err, exp_err);
      chk("rsp_rdata_stall", rsp_rdata, exp_rd);
      chk("sel_en_in_resp", sel_en, 0);
      chk("cmd_ready_in_resp", cmd_ready, 0);
    end

    ack       = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    edges++;
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("cmd_ready_after_hs", cmd_ready, 1);
    chk("busy_after_hs", busy, 0);
    chk("sel_en_gap", sel_en, 0);
    chk("cycles_per_cmd", edges, 1 + exp_sel + rsp_wait + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    rsp_ready = 1'b0;
    rd_data   = 8'h00;
    ack       = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_sel_en", sel_en, 0);
    chk("reset_wr_rd_s", wr_rd_s, 0);
    chk("reset_addr", addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // Write with ack on the second ACCESS cycle.
    do_cmd(1'b1, 8'h02, 8'hA5, 2, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Read with immediate ack; also the 3-cycle throughput case.
    do_cmd(1'b0, 8'h01, 8'h77, 1, 8'h3C, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Out-of-range address.
    do_cmd(1'b0, 8'h07, 8'h00, 1, 8'hEE, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Timeout, then ack in the final cycle, then ack one cycle too late.
    do_cmd(1'b0, 8'h00, 8'h00, 0, 8'h99, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_cmd(1'b0, 8'h00, 8'h00, TIMEOUT, 8'h99, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_cmd(1'b0, 8'h00, 8'h00, TIMEOUT + 1, 8'h99, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    // Response back-pressure with a second command waiting.
    do_cmd(1'b0, 8'h03, 8'h00, 3, 8'h42, 5, 1'b1, 1'b1, 8'h01, 8'hC3);
    do_cmd(1'b1, 8'h01, 8'hC3, 1, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset in the middle of an access.
    cmd_valid = 1'b1;
    cmd_wr    = 1'b0;
    cmd_addr  = 8'h00;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("sel_en_before_reset", sel_en, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_sel_en", sel_en, 0);
    chk("async_reset_rsp_valid", rsp_valid, 0);
    chk("async_reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("no_rsp_after_reset", rsp_valid, 0);
    chk("cmd_ready_after_mid_reset", cmd_ready, 1);
    do_cmd(1'b1, 8'h03, 8'h5A, 1, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Randomized commands, including out-of-range addresses and late acks.
    for (int n = 0; n < 30; n++) begin
      logic       rwr;
      logic [7:0] ra;
      logic [7:0] rwd;
      logic [7:0] rrd;
      int         rack;
      int         rwait;
      rwr   = 1'($urandom);
      ra    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      rwd   = 8'($urandom);
      rrd   = 8'($urandom);
      rack  = $urandom_range(0, TIMEOUT + 2);
      rwait = $urandom_range(0, 3);
      do_cmd(rwr, ra, rwd, rack, rrd, rwait, 1'b0, 1'b0, 8'h00, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
